// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO sizing and Gray/binary pointer conversion helpers.
package fifo_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned PTR_W  = ADDR_W + 1;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // XOR prefix from the MSB down
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = int'(PTR_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
module ptr_sync_2ff #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= '0;
      q  <= '0;
    end else begin
      d1 <= d;
      q  <= d1;
    end
  end

endmodule

// File: rtl/w_ctrl_async.sv
// Write-side pointer and flag controller of the dual-clock FIFO (write clock domain only).
module w_ctrl_async #(
  parameter int unsigned ADDR_W    = fifo_pkg::ADDR_W,
  parameter int unsigned AF_THRESH = 240
) (
  input  logic            w_clk,
  input  logic            rst,
  input  logic            w_en,
  input  logic            ovf_clr,
  input  logic [ADDR_W:0] r_gaddr,
  output logic            w_mem_en,
  output logic [ADDR_W:0] w_addr,
  output logic [ADDR_W:0] w_gaddr,
  output logic            w_full,
  output logic            w_almost_full,
  output logic [ADDR_W:0] w_level,
  output logic            w_overflow
);

  import fifo_pkg::*;

  localparam int unsigned PW = ADDR_W + 1;

  logic [PW-1:0] rg_d2;
  logic [PW-1:0] rb_sync;
  logic [PW-1:0] addr_nxt;
  logic [PW-1:0] gaddr_nxt;
  logic [PW-1:0] lvl_nxt;
  logic [PW-1:0] full_gray;

  ptr_sync_2ff #(.W(PW)) u_rsync (
    .clk (w_clk),
    .rst (rst),
    .d   (r_gaddr),
    .q   (rg_d2)
  );

  assign w_mem_en = w_en & ~w_full & ~rst;

  // Flags are judged against the pointer after this edge's write
  always_comb begin
    addr_nxt  = w_addr + PW'(w_en & ~w_full);
    gaddr_nxt = bin2gray(addr_nxt);
    rb_sync   = gray2bin(rg_d2);
    lvl_nxt   = addr_nxt - rb_sync;
    full_gray = {~rg_d2[ADDR_W -: 2], rg_d2[ADDR_W-2:0]};
  end

  always_ff @(posedge w_clk) begin
    if (rst) begin
      w_addr        <= '0;
      w_gaddr       <= '0;
      w_full        <= 1'b0;
      w_almost_full <= 1'b0;
      w_level       <= '0;
      w_overflow    <= 1'b0;
    end else begin
      w_addr        <= addr_nxt;
      w_gaddr       <= gaddr_nxt;
      w_full        <= (gaddr_nxt == full_gray);
      w_almost_full <= (lvl_nxt >= PW'(AF_THRESH));
      w_level       <= lvl_nxt;
      // a rejected write wins over a same-edge clear
      if (w_en && w_full) begin
        w_overflow <= 1'b1;
      end else if (ovf_clr) begin
        w_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_w_ctrl_async.sv
// Randomized and directed bench for w_ctrl_async against a modular-arithmetic FIFO occupancy model.
module tb_w_ctrl_async;

  logic       w_clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [8:0] r_gaddr = '0;
  logic       w_mem_en;
  logic [8:0] w_addr;
  logic [8:0] w_gaddr;
  logic       w_full;
  logic       w_almost_full;
  logic [8:0] w_level;
  logic       w_overflow;

  w_ctrl_async #(.ADDR_W(8), .AF_THRESH(240)) dut (
    .w_clk         (w_clk),
    .rst           (rst),
    .w_en          (w_en),
    .ovf_clr       (ovf_clr),
    .r_gaddr       (r_gaddr),
    .w_mem_en      (w_mem_en),
    .w_addr        (w_addr),
    .w_gaddr       (w_gaddr),
    .w_full        (w_full),
    .w_almost_full (w_almost_full),
    .w_level       (w_level),
    .w_overflow    (w_overflow)
  );

  always #5 w_clk = ~w_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference: pointers as plain counters mod 512, read pointer seen two edges late
  int rptr    = 0;
  int m_waddr = 0;
  int m_level = 0;
  int rs1     = 0;
  int rs2     = 0;
  bit m_full  = 1'b0;
  bit m_af    = 1'b0;
  bit m_ovf   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit en, input bit clr, input bit r);
    int wr;
    int nxt;
    int lvl;
    if (r) begin
      m_waddr = 0; m_level = 0; rs1 = 0; rs2 = 0;
      m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      wr  = (en && !m_full) ? 1 : 0;
      nxt = (m_waddr + wr) & 511;
      lvl = (nxt - rs2) & 511;
      if (en && m_full) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_full  = (lvl == 256);
      m_af    = (lvl >= 240);
      m_level = lvl;
      m_waddr = nxt;
      rs2 = rs1;
      rs1 = rptr;
    end
  endtask

  // one clock: drive while clk low, check strobe, clock, check registered outputs
  task automatic step(input bit en, input bit clr, input bit r);
    int g;
    rst = r; w_en = en; ovf_clr = clr;
    g = (rptr ^ (rptr >> 1)) & 511;
    r_gaddr = 9'(g);
    #1 check_val("w_mem_en", 32'(w_mem_en), 32'(en && !m_full && !r));
    @(posedge w_clk);
    model_edge(en, clr, r);
    #1;
    check_val("w_addr", 32'(w_addr), 32'(m_waddr));
    check_val("w_gaddr", 32'(w_gaddr), 32'((m_waddr ^ (m_waddr >> 1)) & 511));
    check_val("w_full", 32'(w_full), 32'(m_full));
    check_val("w_almost_full", 32'(w_almost_full), 32'(m_af));
    check_val("w_level", 32'(w_level), 32'(m_level));
    check_val("w_overflow", 32'(w_overflow), 32'(m_ovf));
    @(negedge w_clk);
  endtask

  initial begin
    @(negedge w_clk);

    // reset held with writes requested
    rptr = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    check_val("rst_addr", 32'(w_addr), 32'h0);
    check_val("rst_level", 32'(w_level), 32'h0);

    // fill 256 words with the reader parked at zero
    for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 1'b0);
    check_val("fill_addr", 32'(w_addr), 32'h100);
    check_val("fill_gaddr", 32'(w_gaddr), 32'h180);
    check_val("fill_full", 32'(w_full), 32'h1);
    check_val("fill_level", 32'(w_level), 32'd256);
    step(1'b1, 1'b0, 1'b0);
    check_val("ovf_addr_hold", 32'(w_addr), 32'h100);
    check_val("ovf_set", 32'(w_overflow), 32'h1);

    // one read frees a slot; full drops on the third edge
    rptr = 1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_val("drain_full_e2", 32'(w_full), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check_val("drain_full_e3", 32'(w_full), 32'h0);
    check_val("drain_level", 32'(w_level), 32'd255);
    step(1'b1, 1'b0, 1'b0);
    check_val("refill_full", 32'(w_full), 32'h1);
    check_val("refill_addr", 32'(w_addr), 32'h101);

    // sticky overflow: clear, then set beats clear
    step(1'b0, 1'b1, 1'b0);
    check_val("ovf_clr", 32'(w_overflow), 32'h0);
    step(1'b1, 1'b1, 1'b0);
    check_val("ovf_set_prio", 32'(w_overflow), 32'h1);

    // almost-full threshold
    rptr = 0;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 239; i++) step(1'b1, 1'b0, 1'b0);
    check_val("af_239", 32'(w_almost_full), 32'h0);
    check_val("lvl_239", 32'(w_level), 32'd239);
    step(1'b1, 1'b0, 1'b0);
    check_val("af_240", 32'(w_almost_full), 32'h1);
    check_val("lvl_240", 32'(w_level), 32'd240);

    // pointer wrap with the reader tracking the writer
    rptr = 0;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 600 && m_waddr != 511; i++) begin
      rptr = m_waddr;
      step(1'b1, 1'b0, 1'b0);
    end
    check_val("pre_wrap_addr", 32'(w_addr), 32'h1FF);
    check_val("pre_wrap_gaddr", 32'(w_gaddr), 32'h100);
    rptr = m_waddr;
    step(1'b1, 1'b0, 1'b0);
    check_val("wrap_addr", 32'(w_addr), 32'h0);
    check_val("wrap_gaddr", 32'(w_gaddr), 32'h0);
    check_val("wrap_full", 32'(w_full), 32'h0);

    // random traffic with legal reader progress and rare resets
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit en;
      bit clr;
      r   = ($urandom % 256) == 0;
      en  = ($urandom % 4) != 0;
      clr = ($urandom % 8) == 0;
      if (r) rptr = 0;
      else if ((((m_waddr - rptr) & 511) != 0) && ($urandom % 2 == 1)) rptr = (rptr + 1) & 511;
      step(en, clr, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/w_ctrl_async.md
Name: w_ctrl_async

Overview:
Write-side pointer and flag controller for the team's dual-clock FIFO. It is the counterpart of the read-side controller and runs entirely in the write clock domain.
- Keeps the binary write address for the RAM and a Gray-coded write pointer for the read domain.
- Pulls in the read side's Gray pointer through a 2-flop synchronizer and produces full, almost-full, fill level and a sticky overflow flag.
- Sits between the producer and the shared dual-port RAM.

Parameters:
ADDR_W, 8, RAM address bits; pointers are ADDR_W+1 bits (MSB = wrap bit); depth = 2**ADDR_W = 256
AF_THRESH, 240, fill level at or above which w_almost_full asserts (range 1..2**ADDR_W)

Ports:
w_clk  in  1  write clock
rst  in  1  synchronous reset, active high
w_en  in  1  producer write request
ovf_clr  in  1  clears sticky w_overflow
r_gaddr  in  ADDR_W+1  read-side Gray pointer (read-clock domain, asynchronous here)
w_mem_en  out  1  RAM write strobe = w_en & ~w_full (combinational)
w_addr  out  ADDR_W+1  binary write pointer; RAM uses w_addr[ADDR_W-1:0]
w_gaddr  out  ADDR_W+1  Gray write pointer, registered, for read-domain sync
w_full  out  1  FIFO full
w_almost_full  out  1  level >= AF_THRESH
w_level  out  ADDR_W+1  fill-level estimate, 0..2**ADDR_W
w_overflow  out  1  sticky: a write was attempted while full

Behaviour:
- All flops update on posedge w_clk. rst is sampled synchronously.
- Reset values: w_addr=0, w_gaddr=0, sync stages=0, w_full=0, w_almost_full=0, w_level=0, w_overflow=0.
- Reset mid-operation: all state clears on the next edge. w_mem_en is forced 0 while rst=1.
- Synchronizer: {rg_d2, rg_d1} <= {rg_d1, r_gaddr}. Only rg_d2 is used by any logic.
- Next pointer: addr_nxt = w_addr + (w_en & ~w_full), modulo 2**(ADDR_W+1). Wrap 9'h1FF -> 9'h000 is natural.
- Gray pointer: gaddr_nxt = (addr_nxt >> 1) ^ addr_nxt. w_gaddr <= gaddr_nxt, so it changes one bit at a time.
- Full: w_full <= (gaddr_nxt == {~rg_d2[ADDR_W:ADDR_W-1], rg_d2[ADDR_W-2:0]}).
  - Because the compare uses the next pointer, full is asserted on the same edge as the write that fills the last slot.
  - Full is pessimistic: it deasserts 3 w_clk edges after r_gaddr changes (2 sync edges + 1 flag edge).
- Level: rb_sync = Gray-to-binary of rg_d2, combinational XOR prefix from the MSB.
  - w_level <= addr_nxt - rb_sync, modulo 2**(ADDR_W+1). The result is always in 0..2**ADDR_W.
  - Level lags by one edge after synchronization.
- Almost full: w_almost_full <= ((addr_nxt - rb_sync) >= AF_THRESH), computed in parallel with w_level.
- Overflow: if (w_en & w_full) then w_overflow <= 1; else if ovf_clr then w_overflow <= 0. Set has priority over clear on the same edge.
- Write while full: w_mem_en=0 and w_addr/w_gaddr hold. Only w_overflow reacts.
- Simultaneous write and read pointer advance: handled by the modular arithmetic; no special case.
- No combinational path from r_gaddr to any output.

Decomposition:
- Shared package fifo_pkg holds ADDR_W, DEPTH = 2**ADDR_W, PTR_W = ADDR_W+1, and functions bin2gray and gray2bin.
- The read-side controller is refactored to use the same package.
- One sub-module: ptr_sync_2ff, a parameterised-width 2-flop synchronizer with synchronous active-high reset. It is reused by the read side for w_gaddr.

Test Plan:
- Reset: hold rst 3 cycles with w_en=1 -> all outputs 0, w_mem_en=0, w_addr stays 0.
- Fill: r_gaddr=0, w_en=1 for 256 cycles -> w_addr=9'h100, w_gaddr=9'h180, w_full=1 on the edge of the 256th write, w_level=256; a 257th w_en leaves w_addr at 9'h100 and sets w_overflow.
- Drain release: from full, set r_gaddr=9'h001 -> w_full=0 on the 3rd edge, w_level=255; one write re-asserts w_full and w_addr=9'h101.
- Almost full: r_gaddr=0, write 239 words -> w_almost_full=0; 240th write -> w_almost_full=1 registered with w_level=240.
- Wrap: preload via writes/reads so w_addr=9'h1FF and r_gaddr tracks near it; one write -> w_addr=9'h000, w_gaddr=9'h000 from 9'h100, w_full=0.
- Overflow clear: with w_overflow=1, pulse ovf_clr with w_en=0 -> w_overflow=0 next edge; ovf_clr=1 with w_en&w_full -> w_overflow stays 1.
